// File: rtl/sevseg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: glyph table,
// the all-segments-off pattern and the largest supported digit count.
package sevseg_pkg;

    localparam int MAX_DIGITS = 8;

    // Segment order gfedcba, active-low (common anode).
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6 with top tail
        7'b1111000,  // 7 without segment f
        7'b0000000,  // 8
        7'b0010000,  // 9 with bottom tail
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/sevseg_digit_dec.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module sevseg_digit_dec
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = glyph_of(nibble);

endmodule

// File: rtl/sevseg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with tear-free,
// frame-synchronous updates. Optional leading-zero blanking: SEVSEG_LZB_EN.
module sevseg_mux_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    input  logic                    blank_i,
    output logic [6:0]              sevseg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    pending_o,
    output logic                    frame_o
);

    localparam int IDX_W = $clog2(MAX_DIGITS);
    localparam int PS_W  = $clog2(REFRESH_DIV);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]         presc_p0;
    logic [IDX_W-1:0]        index_p0;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic [3:0]              nibble;
    logic                    dp_bit;
    logic [6:0]              glyph;
    logic [6:0]              seg_lit;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    dark;

    // Stage p0: prescaler and digit index
    assign slot_end  = (presc_p0 == PS_LAST);
    assign frame_end = slot_end && (index_p0 == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_p0 <= '0;
            index_p0 <= '0;
        end else if (slot_end) begin
            presc_p0 <= '0;
            index_p0 <= (index_p0 == IDX_LAST) ? '0 : index_p0 + IDX_W'(1);
        end else begin
            presc_p0 <= presc_p0 + PS_W'(1);
        end
    end

    // Shadow takes every load; the display only changes on a frame boundary,
    // where a coincident load bypasses the shadow so nothing is left pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending_o  <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
            if (frame_end) begin
                disp_val  <= load_i ? value_i : shadow_val;
                disp_dp   <= load_i ? dp_i    : shadow_dp;
                pending_o <= 1'b0;
            end else if (load_i) begin
                pending_o <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble = '0;
        dp_bit = 1'b0;
        an_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_p0 == IDX_W'(k)) begin
                nibble    = disp_val[4*k +: 4];
                dp_bit    = disp_dp[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    sevseg_digit_dec u_dec (
        .nibble (nibble),
        .glyph  (glyph)
    );

`ifdef SEVSEG_LZB_EN
    logic [IDX_W-1:0] top_digit;

    // Highest nonzero nibble; digit 0 stays lit because index 0 is never above it.
    always_comb begin
        top_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (disp_val[4*k +: 4] != 4'h0) begin
                top_digit = IDX_W'(k);
            end
        end
    end

    assign seg_lit = (index_p0 > top_digit) ? SEG_OFF : glyph;
`else
    assign seg_lit = glyph;
`endif

    // Slot 0 of every digit is dead time so two anodes never overlap.
    assign dark = blank_i || (presc_p0 == '0);

    // Stage p1: registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o     <= '1;
            sevseg_o <= SEG_OFF;
            dp_o     <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            an_o     <= dark ? '1 : an_sel;
            sevseg_o <= dark ? SEG_OFF : seg_lit;
            dp_o     <= dark | ~dp_bit;
            frame_o  <= frame_end;
        end
    end

endmodule
